// File: rtl/apb_cfg_master.sv
// rtl/apb_cfg_master.sv - APB3 initiator turning single-beat commands into config bus transfers
//
// Accepts one command at a time on a valid/ready channel, runs it as an APB3
// SETUP/ACCESS transfer and returns the result on a valid/ready response channel.
//
// Ports:
//   clk, resetn                     clock, synchronous active-low reset
//   cmd_valid_i / cmd_ready_o       command handshake (ready only in IDLE)
//   cmd_addr_i, cmd_wdata_i,
//   cmd_write_i                     command payload
//   rsp_valid_o / rsp_ready_i       response handshake
//   rsp_rdata_o, rsp_err_o,
//   rsp_timeout_o                   response payload
//   busy_o                          high whenever not IDLE
//   paddr_o, pwdata_o, pwrite_o,
//   psel_o, penable_o               APB request (all registered)
//   pready_i, prdata_i, pslverr_i   APB completion (sampled in ACCESS only)
module apb_cfg_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    input  logic                  cmd_write_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic                  pwrite_o,
    output logic                  psel_o,
    output logic                  penable_o,
    input  logic                  pready_i,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pslverr_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // Timeout is disabled entirely when TIMEOUT_CYCLES is 0; TO_LAST is then unused.
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                state_q,       state_d;
    logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
    logic                  pwrite_q,      pwrite_d;
    logic                  psel_q,        psel_d;
    logic                  penable_q,     penable_d;
    logic                  rsp_valid_q,   rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic                  rsp_err_q,     rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [15:0]           cnt_q,         cnt_d;

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    paddr_d  = cmd_addr_i;
                    pwdata_d = cmd_wdata_i;
                    pwrite_d = cmd_write_i;
                    psel_d   = 1'b1;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                // A ready slave wins over a coincident timeout.
                if (pready_i) begin
                    rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
                    rsp_err_d     = pslverr_i;
                    rsp_timeout_d = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = S_RESP;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign cmd_ready_o   = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign pwrite_o      = pwrite_q;
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cfg_master.sv
// tb/tb_apb_cfg_master.sv - directed self-checking bench for apb_cfg_master
module tb_apb_cfg_master;

    logic        clk = 1'b0;
    logic        resetn, resetn_nt;
    logic        cmd_valid, cmd_write, rsp_ready;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        pready, pslverr;
    logic [31:0] prdata;

    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy;
    logic [31:0] rsp_rdata, paddr, pwdata;
    logic        pwrite, psel, penable;

    logic        nt_cmd_ready, nt_rsp_valid, nt_rsp_err, nt_rsp_timeout, nt_busy;
    logic [31:0] nt_rsp_rdata, nt_paddr, nt_pwdata;
    logic        nt_pwrite, nt_psel, nt_penable;

    int checks = 0;
    int errors = 0;
    int psel_rises = 0;
    logic psel_prev = 1'b0;

    always #5 clk = ~clk;

    apb_cfg_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_write_i(cmd_write),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
        .busy_o(busy),
        .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite),
        .psel_o(psel), .penable_o(penable),
        .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
    );

    // Timeout-disabled instance: its slave never answers.
    apb_cfg_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(0)) dut_nt (
        .clk(clk), .resetn(resetn_nt),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(nt_cmd_ready),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_write_i(cmd_write),
        .rsp_valid_o(nt_rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(nt_rsp_rdata), .rsp_err_o(nt_rsp_err), .rsp_timeout_o(nt_rsp_timeout),
        .busy_o(nt_busy),
        .paddr_o(nt_paddr), .pwdata_o(nt_pwdata), .pwrite_o(nt_pwrite),
        .psel_o(nt_psel), .penable_o(nt_penable),
        .pready_i(1'b0), .prdata_i(32'h0), .pslverr_i(1'b0)
    );

    // APB protocol rules and psel pulse counting, sampled mid-cycle.
    always @(negedge clk) begin
        checks++;
        assert (!(penable && !psel)) else begin
            errors++;
            $error("FAIL apb_en_wo_sel: observed penable=%0b psel=%0b expected penable=0", penable, psel);
        end
        checks++;
        assert (!(penable && psel && !psel_prev)) else begin
            errors++;
            $error("FAIL apb_en_first_cycle: observed penable=%0b expected 0", penable);
        end
        if (psel && !psel_prev) psel_rises++;
        psel_prev = psel;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic w);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_write = w;
    endtask

    int rises0;

    initial begin
        resetn = 1'b0; resetn_nt = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
        tick(); tick();

        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        resetn = 1'b1; resetn_nt = 1'b1;

        // Write, zero-wait slave
        pready = 1'b1;
        send(32'h0, 32'h8000_0000, 1'b1);
        tick();                                   // T0
        cmd_valid = 1'b0;
        chk("w0_setup_psel", 32'(psel), 32'd1);
        chk("w0_setup_penable", 32'(penable), 32'd0);
        chk("w0_pwdata", pwdata, 32'h8000_0000);
        chk("w0_pwrite", 32'(pwrite), 32'd1);
        chk("w0_busy", 32'(busy), 32'd1);
        tick();                                   // T0+1
        chk("w0_access_psel", 32'(psel), 32'd1);
        chk("w0_access_penable", 32'(penable), 32'd1);
        tick();                                   // T0+2
        chk("w0_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("w0_rsp_psel", 32'(psel), 32'd0);
        chk("w0_rsp_err", 32'(rsp_err), 32'd0);
        chk("w0_rsp_rdata", rsp_rdata, 32'h0);
        chk("w0_cmd_ready", 32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        tick();
        chk("w0_done_valid", 32'(rsp_valid), 32'd0);
        chk("w0_done_busy", 32'(busy), 32'd0);
        rsp_ready = 1'b0;

        // Write, registered-pready slave (one wait cycle)
        pready = 1'b0;
        rises0 = psel_rises;
        send(32'h3, 32'h2, 1'b1);
        tick();                                   // T0
        cmd_valid = 1'b0;
        chk("w1_paddr", paddr, 32'h3);
        tick();                                   // T0+1
        chk("w1_acc1_penable", 32'(penable), 32'd1);
        tick();                                   // T0+2
        chk("w1_acc2_penable", 32'(penable), 32'd1);
        chk("w1_acc2_rsp_valid", 32'(rsp_valid), 32'd0);
        pready = 1'b1;
        tick();                                   // T0+3
        pready = 1'b0;
        chk("w1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("w1_psel_off", 32'(psel), 32'd0);
        chk("w1_single_psel", 32'(psel_rises - rises0), 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Read with slave error after 3 wait cycles
        send(32'h1, 32'h0, 1'b0);
        tick();                                   // T0
        cmd_valid = 1'b0;
        tick();                                   // T0+1, ACCESS
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r_wait_valid", 32'(rsp_valid), 32'd0);
            chk("r_wait_penable", 32'(penable), 32'd1);
        end
        pready = 1'b1; prdata = 32'hDEAD_BEEF; pslverr = 1'b1;
        tick();
        pready = 1'b0; prdata = 32'h0; pslverr = 1'b0;
        chk("r_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("r_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("r_rsp_err", 32'(rsp_err), 32'd1);
        chk("r_rsp_timeout", 32'(rsp_timeout), 32'd0);
        tick();
        chk("r_hold_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("r_hold_err", 32'(rsp_err), 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Timeout: 16 ACCESS cycles then abort
        prdata = 32'h1234_5678;
        send(32'h2, 32'h0, 1'b0);
        tick();                                   // T0
        cmd_valid = 1'b0;
        tick();                                   // T0+1, first ACCESS cycle
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("to_access_%0d", i), 32'({penable, rsp_valid}), 32'b10);
            tick();
        end
        chk("to_psel", 32'(psel), 32'd0);
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
        chk("to_rsp_rdata", rsp_rdata, 32'h0);
        prdata = 32'h0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Back-pressure with a second command waiting
        pready = 1'b1;
        send(32'h4, 32'h55, 1'b1);
        tick();                                   // T0
        send(32'h5, 32'hAA, 1'b1);
        tick(); tick();                           // RESP
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        rises0 = psel_rises;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_psel", 32'(psel), 32'd0);
            chk("bp_paddr", paddr, 32'h4);
            chk("bp_rdata", rsp_rdata, 32'h0);
        end
        chk("bp_no_psel_pulse", 32'(psel_rises - rises0), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
        chk("bp_idle_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("bp_second_psel", 32'(psel), 32'd1);
        chk("bp_second_paddr", paddr, 32'h5);
        chk("bp_second_pwdata", pwdata, 32'hAA);
        tick(); tick();
        chk("bp_second_rsp", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Timeout disabled: dut_nt has been waiting since its first command
        repeat (1000) tick();
        chk("nt_psel", 32'(nt_psel), 32'd1);
        chk("nt_penable", 32'(nt_penable), 32'd1);
        chk("nt_rsp_valid", 32'(nt_rsp_valid), 32'd0);
        chk("nt_busy", 32'(nt_busy), 32'd1);

        // Reset during ACCESS
        pready = 1'b0;
        send(32'h6, 32'h77, 1'b1);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rs_in_access", 32'(penable), 32'd1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("rs_psel", 32'(psel), 32'd0);
        chk("rs_penable", 32'(penable), 32'd0);
        chk("rs_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rs_cmd_ready", 32'(cmd_ready), 32'd1);
        pready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rs_no_rsp", 32'({rsp_valid, psel, busy}), 32'b000);
        end
        pready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
